commit_trace_tx: RTL and testbench

Trace transmitter for the pipelined MIPS core. It captures architectural side effects at commit: write-back register writes and data-memory stores. It queues them as sequenced records and streams them out over a valid/ready interface to a trace consumer, such as a bench printer or an off-chip logger. It sits beside the core, tapping the WB-stage and MEM-stage control and data signals. On `finish` it drains its queue and then raises `done`.

---
 rtl/trace_pkg.sv | 20 ++
 rtl/trace_fifo.sv | 51 +++++
 rtl/commit_trace_tx.sv | 110 +++++++++++
 tb/tb_commit_trace_tx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared encodings for the commit trace transmitter: record kinds, FSM states
// and the packed record width {kind, addr, data, seq}.
package trace_pkg;

    localparam logic [1:0] TR_REG  = 2'd0;
    localparam logic [1:0] TR_MEMW = 2'd1;

    localparam int TR_FIXED_W = 2 + 32 + 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int rec_w(input int seq_w);
        return TR_FIXED_W + seq_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO with two ordered write ports (port 0 older) and one pop port.
// Storage is not reset; only pointers and count are.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 82
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [WIDTH-1:0]         wd0,
    input  logic                     we1,
    input  logic [WIDTH-1:0]         wd1,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [1:0]       n_push;
    logic             do_pop;

    assign n_push = {1'b0, we0} + {1'b0, we1};
    assign do_pop = pop && (count != '0);
    assign empty  = (count == '0);
    assign rd     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (we0) mem[wr_ptr] <= wd0;
        // Port 1 lands behind port 0 when both write, otherwise at the tail.
        if (we1) mem[we0 ? wr_ptr + AW'(1) : wr_ptr] <= wd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(n_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/commit_trace_tx.sv
// Commit trace transmitter: filters WB register writes and MEM stores into
// sequenced records, queues them and streams them out over valid/ready.
module commit_trace_tx
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_write_reg,
    input  logic [31:0]      wb_data,
    input  logic             mem_write,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic             finish,
    input  logic             tr_ready,
    output logic             tr_valid,
    output logic [1:0]       tr_kind,
    output logic [31:0]      tr_addr,
    output logic [31:0]      tr_data,
    output logic [SEQ_W-1:0] tr_seq,
    output logic             overflow,
    output logic [7:0]       drop_count,
    output logic             done
);

    localparam int REC_W = rec_w(SEQ_W);
    localparam int CW    = $clog2(DEPTH) + 1;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    state_t            state, state_nxt;
    logic [SEQ_W-1:0]  seq;
    logic [CW-1:0]     count;
    logic [CW-1:0]     free;
    logic              fifo_empty;
    logic [REC_W-1:0]  head;
    logic [REC_W-1:0]  reg_rec, mem_rec;
    logic              reg_ev, mem_ev, acc_reg, acc_mem;
    logic              we0, we1, pop_fire;
    logic [1:0]        n_drop;

    assign reg_ev = (state == ST_RUN) && wb_reg_write && (wb_write_reg != 5'd0);
    assign mem_ev = (state == ST_RUN) && mem_write;

    // Space is judged on the pre-edge count; a same-edge pop does not help.
    assign free    = CW'(DEPTH) - count;
    assign acc_reg = reg_ev && (free != '0);
    assign acc_mem = mem_ev && (reg_ev ? (free >= CW'(2)) : (free != '0));
    assign n_drop  = {1'b0, reg_ev && !acc_reg} + {1'b0, mem_ev && !acc_mem};

    assign reg_rec = {TR_REG, 27'd0, wb_write_reg, wb_data, seq};
    assign mem_rec = {TR_MEMW, mem_addr, mem_wdata, seq + SEQ_W'(reg_ev)};

    assign we0 = acc_reg;
    assign we1 = acc_mem;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .we0   (we0),
        .wd0   (reg_rec),
        .we1   (we1),
        .wd1   (mem_rec),
        .pop   (tr_ready),
        .rd    (head),
        .empty (fifo_empty),
        .count (count)
    );

    assign tr_valid = !fifo_empty;
    assign pop_fire = tr_valid && tr_ready;
    // Fields read as zero while idle so reset clears them without touching storage.
    assign {tr_kind, tr_addr, tr_data, tr_seq} = tr_valid ? head : '0;
    assign done = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (finish) state_nxt = ST_DRAIN;
            ST_DRAIN: if ((count == '0) || ((count == CW'(1)) && pop_fire)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            state      <= state_nxt;
            seq        <= seq + SEQ_W'(reg_ev) + SEQ_W'(mem_ev);
            if (n_drop != 2'd0) overflow <= 1'b1;
            drop_count <= sat_add(drop_count, n_drop);
        end
    end

endmodule

// File: tb/tb_commit_trace_tx.sv
// Bench for commit_trace_tx: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_commit_trace_tx;

    localparam int DEPTH = 8;
    localparam int SEQ_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             wb_reg_write = 1'b0;
    logic [4:0]       wb_write_reg = '0;
    logic [31:0]      wb_data = '0;
    logic             mem_write = 1'b0;
    logic [31:0]      mem_addr = '0;
    logic [31:0]      mem_wdata = '0;
    logic             finish = 1'b0;
    logic             tr_ready = 1'b0;
    logic             tr_valid;
    logic [1:0]       tr_kind;
    logic [31:0]      tr_addr;
    logic [31:0]      tr_data;
    logic [SEQ_W-1:0] tr_seq;
    logic             overflow;
    logic [7:0]       drop_count;
    logic             done;

    commit_trace_tx #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .reset(reset),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_data(wb_data),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .finish(finish), .tr_ready(tr_ready),
        .tr_valid(tr_valid), .tr_kind(tr_kind), .tr_addr(tr_addr), .tr_data(tr_data),
        .tr_seq(tr_seq), .overflow(overflow), .drop_count(drop_count), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of records plus phase/seq/drop bookkeeping.
    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          seq;
    } rec_t;

    rec_t q[$];
    int   m_seq   = 0;
    int   m_drop  = 0;
    bit   m_ovf   = 0;
    int   m_phase = 0;

    task automatic model_event(input logic [1:0] kind, input logic [31:0] a,
                               input logic [31:0] d, input int n0, inout int acc);
        rec_t r;
        if (n0 + acc < DEPTH) begin
            r.kind = kind; r.addr = a; r.data = d; r.seq = m_seq;
            q.push_back(r);
            acc++;
        end else begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
        end
        m_seq = (m_seq + 1) % (1 << SEQ_W);
    endtask

    always @(posedge clk or posedge reset) begin
        int n0;
        int acc;
        bit popf;
        if (reset) begin
            q.delete();
            m_seq = 0; m_drop = 0; m_ovf = 0; m_phase = 0;
        end else begin
            n0   = q.size();
            popf = (n0 != 0) && tr_ready;
            acc  = 0;
            if (m_phase == 0) begin
                if (wb_reg_write && wb_write_reg != 5'd0)
                    model_event(2'd0, {27'd0, wb_write_reg}, wb_data, n0, acc);
                if (mem_write)
                    model_event(2'd1, mem_addr, mem_wdata, n0, acc);
            end
            if (popf) void'(q.pop_front());
            if (m_phase == 0 && finish) m_phase = 1;
            else if (m_phase == 1 && q.size() == 0) m_phase = 2;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("m_valid", tr_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("m_kind", tr_kind, q[0].kind);
                chk("m_addr", tr_addr, q[0].addr);
                chk("m_data", tr_data, q[0].data);
                chk("m_seq", tr_seq, q[0].seq);
            end
            chk("m_overflow", overflow, m_ovf);
            chk("m_drop", drop_count, m_drop);
            chk("m_done", done, m_phase == 2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_reg_write = 0; wb_write_reg = 0; wb_data = 0;
        mem_write = 0; mem_addr = 0; mem_wdata = 0; finish = 0;
    endtask

    task automatic set_reg(input logic [4:0] r, input logic [31:0] d);
        wb_reg_write = 1; wb_write_reg = r; wb_data = d;
    endtask

    task automatic set_mem(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1; mem_addr = a; mem_wdata = d;
    endtask

    task automatic do_reset(input string tag);
        reset = 1;
        #1;
        chk({tag, "_rst_valid"}, tr_valid, 0);
        chk({tag, "_rst_fields"}, {tr_kind, tr_seq} | tr_addr | tr_data, 0);
        chk({tag, "_rst_ovf"}, overflow, 0);
        chk({tag, "_rst_drop"}, drop_count, 0);
        chk({tag, "_rst_done"}, done, 0);
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        do_reset("init");

        // Single REG write, popped the next edge.
        tr_ready = 1; set_reg(5'd8, 32'd5);
        step(); idle();
        chk("single_valid", tr_valid, 1);
        chk("single_kind", tr_kind, 0);
        chk("single_addr", tr_addr, 8);
        chk("single_data", tr_data, 5);
        chk("single_seq", tr_seq, 0);
        step();
        chk("single_popped", tr_valid, 0);

        // $0 filter followed by a dual event.
        do_reset("dual");
        tr_ready = 0; set_reg(5'd0, 32'h1234);
        step(); idle();
        chk("zero_filtered", tr_valid, 0);
        set_reg(5'd9, 32'd7); set_mem(32'd4, 32'hDEAD);
        step(); idle();
        chk("dual_first_kind", tr_kind, 0);
        chk("dual_first_seq", tr_seq, 0);
        tr_ready = 1;
        step();
        chk("dual_second_kind", tr_kind, 1);
        chk("dual_second_addr", tr_addr, 4);
        chk("dual_second_data", tr_data, 32'hDEAD);
        chk("dual_second_seq", tr_seq, 1);
        step();
        chk("dual_empty", tr_valid, 0);

        // Backpressure and overflow.
        do_reset("ovf");
        tr_ready = 0;
        for (int i = 0; i < 5; i++) begin
            set_reg(5'(i + 1), 32'h100 + i); set_mem(32'h40 + i, 32'h200 + i);
            step();
        end
        idle();
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_count, 2);
        repeat (3) step();
        chk("ovf_hold_seq", tr_seq, 0);
        chk("ovf_hold_data", tr_data, 32'h100);
        tr_ready = 1;
        step();
        set_reg(5'd20, 32'hCAFE);
        step(); idle();
        repeat (6) step();
        chk("ovf_next_seq", tr_seq, 10);
        chk("ovf_next_data", tr_data, 32'hCAFE);
        repeat (2) step();

        // Sequence wrap with SEQ_W = 4.
        do_reset("wrap");
        tr_ready = 1;
        for (int i = 0; i < 17; i++) begin
            set_reg(5'((i % 31) + 1), i);
            step();
            chk("wrap_seq", tr_seq, i % 16);
        end
        idle();
        step();

        // Drain with ready toggling; events stay asserted but must be ignored.
        do_reset("drain");
        tr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_reg(5'd3, i); step();
        end
        finish = 1; set_reg(5'd4, 32'h33);
        step();
        chk("drain_not_done", done, 0);
        set_mem(32'h80, 32'h99);
        for (int i = 1; i <= 9; i++) begin
            tr_ready = (i % 2 == 1);
            step();
            if (i == 6) chk("drain_done_early", done, 0);
            if (i == 7) chk("drain_done_rise", done, 1);
        end
        chk("drain_done_held", done, 1);
        chk("drain_no_capture", tr_valid, 0);
        idle();

        // Mid-operation asynchronous reset.
        do_reset("mid_pre");
        tr_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_reg(5'd7, 32'hA0 + i); step();
        end
        idle();
        chk("mid_queued", tr_valid, 1);
        do_reset("mid");
        set_reg(5'd11, 32'h55);
        step(); idle();
        chk("mid_after_seq", tr_seq, 0);
        chk("mid_after_valid", tr_valid, 1);
        step();

        // Randomized traffic, then finish and drain.
        do_reset("rand");
        for (int i = 0; i < 400; i++) begin
            wb_reg_write = 1'($urandom_range(0, 1));
            wb_write_reg = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            wb_data      = $urandom;
            mem_write    = 1'($urandom_range(0, 1));
            mem_addr     = $urandom;
            mem_wdata    = $urandom;
            tr_ready     = ($urandom_range(0, 3) != 0);
            step();
        end
        finish = 1;
        for (int i = 0; i < 40; i++) begin
            wb_reg_write = 1'($urandom_range(0, 1));
            wb_write_reg = 5'($urandom);
            mem_write    = 1'($urandom_range(0, 1));
            tr_ready     = (i > 20) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
        idle();
        chk("rand_done", done, 1);
        chk("rand_empty", tr_valid, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
